mult_div: RTL and testbench

//   Iterative signed multiply/divide unit that produces the HI and LO registers for MULT/DIV.
//   HI and LO are two of the sources selected by the register-file write-data mux.

---
 rtl/mult_div.sv | 152 +++++++++++++++
 tb/tb_mult_div.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// mult_div: iterative signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
// One iteration per clock; DATA_W iterations plus one result-write edge per operation.
`default_nettype none

module mult_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam int                CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_ITER = CNT_W'(DATA_W);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W:0]     acc_q;     // Booth upper half (with guard bit) / partial remainder
    logic [DATA_W-1:0]   qr_q;      // multiplier shifting out / quotient shifting in
    logic                qm1_q;
    logic [DATA_W:0]     m_q;       // sign-extended multiplicand / zero-extended divisor magnitude
    logic                qneg_q;
    logic                rneg_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                busy_q, done_q, dz_q;

    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     booth_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W+1:0]   div_diff;
    logic                div_ge;
    logic [DATA_W:0]     acc_d;
    logic [DATA_W-1:0]   qr_d;
    logic [DATA_W-1:0]   quot_fin, rem_fin;

    always_comb begin
        a_mag     = a[DATA_W-1] ? -a : a;
        b_mag     = b[DATA_W-1] ? -b : b;
        booth_sum = acc_q;
        case ({qr_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase
        div_shift = {acc_q[DATA_W-1:0], qr_q[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, m_q};
        div_ge    = ~div_diff[DATA_W+1];
        if (state_q == S_MULT) begin
            acc_d = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
            qr_d  = {booth_sum[0], qr_q[DATA_W-1:1]};
        end else begin
            acc_d = div_ge ? div_diff[DATA_W:0] : div_shift;
            qr_d  = {qr_q[DATA_W-2:0], div_ge};
        end
        quot_fin = qneg_q ? -qr_q : qr_q;
        rem_fin  = rneg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_mult) begin
                        state_q <= S_MULT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        qr_q    <= b;
                        qm1_q   <= 1'b0;
                        m_q     <= {a[DATA_W-1], a};
                    end else if (start_div) begin
                        if (b == '0) begin
                            dz_q <= 1'b1;
                        end else begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            qr_q    <= a_mag;
                            qm1_q   <= 1'b0;
                            m_q     <= {1'b0, b_mag};
                            qneg_q  <= a[DATA_W-1] ^ b[DATA_W-1];
                            rneg_q  <= a[DATA_W-1];
                        end
                    end
                end
                S_MULT, S_DIV: begin
                    // The edge after the last iteration writes the (sign-corrected) result.
                    if (cnt_q == C_ITER) begin
                        state_q <= S_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (state_q == S_MULT) begin
                            hi_q <= acc_q[DATA_W-1:0];
                            lo_q <= qr_q;
                        end else begin
                            hi_q <= rem_fin;
                            lo_q <= quot_fin;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        acc_q <= acc_d;
                        qr_q  <= qr_d;
                        qm1_q <= qr_q[0];
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: vector table plus scoreboard, and corner-case sequences.
`default_nettype none

module tb_mult_div;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start_mult, start_div;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_zero;

    always #5 clk = ~clk;

    mult_div #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    typedef struct {
        bit           is_div;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    res_t sb[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic res_t model(input bit is_div, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t   r;
        longint sx, sy, p, q, m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!is_div) begin
            p    = sx * sy;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else begin
            q    = sx / sy;
            m    = sx % sy;
            r.hi = m[31:0];
            r.lo = q[31:0];
        end
        return r;
    endfunction

    task automatic start_op(input bit m, input bit d, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x; b = y; start_mult = m; start_div = d;
        @(posedge clk);
        #1;
        start_mult = 1'b0; start_div = 1'b0;
    endtask

    // Called at start edge + 1; poke_cyc injects a start_mult during the op, poke_fin during FINISH.
    task automatic wait_done(input string name, input int poke_cyc, input bit poke_fin);
        int   lat = 0;
        bit   got = 1'b0;
        res_t e;
        check({name, " busy_after_start"}, 64'(busy), 64'd1);
        for (int i = 1; i <= 40 && !got; i++) begin
            if (i == poke_cyc) begin
                start_mult = 1'b1; a = 32'd5; b = 32'd5;
            end
            @(posedge clk);
            #1;
            start_mult = 1'b0;
            lat = i;
            if (done) got = 1'b1;
        end
        check({name, " done_seen"}, 64'(got), 64'd1);
        check({name, " latency"}, 64'(lat), 64'd33);
        check({name, " busy_in_finish"}, 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check({name, " scoreboard_entry"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({name, " hi"}, 64'(hi), 64'(e.hi));
            check({name, " lo"}, 64'(lo), 64'(e.lo));
            if (poke_fin) begin
                start_mult = 1'b1; a = 32'd9; b = 32'd9;
            end
            @(posedge clk);
            #1;
            start_mult = 1'b0;
            check({name, " done_one_cycle"}, 64'(done), 64'd0);
            check({name, " idle_busy"}, 64'(busy), 64'd0);
            check({name, " hi_hold"}, 64'(hi), 64'(e.hi));
        end
    endtask

    initial begin
        res_t r;
        logic [W-1:0] ra, rb;
        bit           rd;

        tbl[0] = '{1'b0, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
        tbl[1] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        tbl[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[3] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{1'b0, 32'd0,         32'd12345,     32'd0,         32'd0};
        tbl[7] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[8] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
        tbl[9] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};

        reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset flags", 64'({busy, done, div_zero}), 64'd0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            start_op(!tbl[i].is_div, tbl[i].is_div, tbl[i].a, tbl[i].b);
            sb.push_back('{tbl[i].hi, tbl[i].lo});
            wait_done($sformatf("vec%0d", i), 0, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rd = i[0];
            if (rd && rb == '0) rb = 32'd3;
            start_op(!rd, rd, ra, rb);
            sb.push_back(model(rd, ra, rb));
            wait_done($sformatf("rand%0d", i), 0, 1'b0);
        end

        // Both starts together: multiply wins.
        start_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF2});
        wait_done("both_starts", 0, 1'b0);

        // Prime hi=0x11, lo=0x22, then divide by zero.
        start_op(1'b0, 1'b1, 32'h451, 32'h20);
        sb.push_back('{32'h11, 32'h22});
        wait_done("prime", 0, 1'b0);
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        check("dz pulse", 64'(div_zero), 64'd1);
        check("dz busy", 64'(busy), 64'd0);
        check("dz done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check("dz one_cycle", 64'(div_zero), 64'd0);
        check("dz busy2", 64'(busy), 64'd0);
        check("dz hi", 64'(hi), 64'h11);
        check("dz lo", 64'(lo), 64'h22);

        // start_mult pulsed at cycle 10 of a divide must be ignored.
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        sb.push_back('{32'd0, 32'h8000_0000});
        wait_done("div_poke", 10, 1'b0);

        // Start during FINISH is ignored.
        start_op(1'b1, 1'b0, 32'd6, 32'd7);
        sb.push_back('{32'd0, 32'd42});
        wait_done("finish_poke", 0, 1'b1);

        // Reset during iteration 15 of a multiply.
        start_op(1'b1, 1'b0, 32'd1000, 32'd1000);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        reset = 1'b1;
        start_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC);
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF4});
        wait_done("after_reset", 0, 1'b0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
